// File: rtl/lvds_sd_pkg.sv
// Shared types and constants for the LVDS sigma-delta ADC front end and its UART framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lvds_sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_RISE,
    ST_WAIT_FALL
  } fsm_state_e;

  localparam int         FRAME_LEN     = 3;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         SAMPLE_W      = 16;

  typedef struct packed {
    logic [7:0] msb;
    logic [7:0] lsb;
  } sample_t;

  // Packet layout: sync byte, then the sample big-endian.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [7:0] sync,
                                            input sample_t    hold);
    case (idx)
      2'd0:    return sync;
      2'd1:    return hold.msb;
      default: return hold.lsb;
    endcase
  endfunction

endpackage

// File: rtl/sd_decimator.sv
// First-order sigma-delta loop: synchronizes the comparator, drives feedback, counts ones per window.
// Latency: comp_in reaches sd_fb and the accumulator 3 clocks later; sample updates once per 2^DEC_W clocks.
// Backpressure: none, free-running; sample_valid is a single-cycle pulse.
module sd_decimator
  import lvds_sd_pkg::*;
#(
  parameter int DEC_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                comp_in,
  output logic                sd_fb,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid
);

  logic                sync1_q, sync1_d;
  logic                comp_s_q, comp_s_d;
  logic                sd_fb_q, sd_fb_d;
  logic [DEC_W-1:0]    win_q, win_d;
  logic [DEC_W:0]      acc_q, acc_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sample_vld_q, sample_vld_d;
  logic                win_end;

  always_comb begin
    sync1_d      = comp_in;
    comp_s_d     = sync1_q;
    sd_fb_d      = comp_s_q;
    win_d        = win_q + DEC_W'(1);
    win_end      = &win_q;
    acc_d        = acc_q + (DEC_W+1)'(comp_s_q);
    sample_d     = sample_q;
    sample_vld_d = win_end;
    // Last clock of the window still contributes its bit to the published sample.
    if (win_end) begin
      sample_d = SAMPLE_W'(acc_d);
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      comp_s_q     <= 1'b0;
      sd_fb_q      <= 1'b0;
      win_q        <= '0;
      acc_q        <= '0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      comp_s_q     <= comp_s_d;
      sd_fb_q      <= sd_fb_d;
      win_q        <= win_d;
      acc_q        <= acc_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
    end
  end

  assign sd_fb        = sd_fb_q;
  assign sample       = sample_q;
  assign sample_valid = sample_vld_q;

endmodule

// File: rtl/lvds_sd_framer.sv
// Sigma-delta ADC plus framer: sends each accepted sample as SYNC, MSB, LSB to the UART TX.
// Latency: first tx_start 2 clocks after sample_valid when tx_busy is low.
// Backpressure: waits on tx_busy per byte; samples arriving mid-packet are dropped and counted.
module lvds_sd_framer
  import lvds_sd_pkg::*;
#(
  parameter int         DEC_W     = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         DROP_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                comp_in,
  output logic                sd_fb,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic [7:0]          tx_dat,
  output logic                tx_start,
  input  logic                tx_busy,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

  fsm_state_e        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  sample_t           hold_q, hold_d;
  logic [7:0]        tx_dat_q, tx_dat_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  sd_decimator #(.DEC_W(DEC_W)) u_dec (
    .clk          (clk),
    .rst          (rst),
    .comp_in      (comp_in),
    .sd_fb        (sd_fb),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    tx_dat_d = tx_dat_q;
    drop_d   = drop_q;

    if (sample_valid && (state_q != ST_IDLE) && (drop_q != {DROP_W{1'b1}}))
      drop_d = drop_q + DROP_W'(1);

    // tx_dat is loaded on entry to LOAD so it is already valid while LOAD waits.
    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          hold_d   = sample;
          idx_d    = 2'd0;
          tx_dat_d = frame_byte(2'd0, SYNC_BYTE, sample);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD:      if (!tx_busy) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: if (tx_busy) state_d = ST_WAIT_FALL;
      ST_WAIT_FALL: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d    = idx_q + 2'd1;
            tx_dat_d = frame_byte(idx_q + 2'd1, SYNC_BYTE, hold_q);
            state_d  = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      hold_q   <= '0;
      tx_dat_q <= 8'd0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      tx_dat_q <= tx_dat_d;
      drop_q   <= drop_d;
    end
  end

  assign tx_start = (state_q == ST_START) && !rst;
  assign tx_dat   = tx_dat_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_lvds_sd_framer.sv
// Bench for lvds_sd_framer: windowed ones-count model and packet-level framer model, plus directed scenarios.
module tb_lvds_sd_framer;
  localparam int W = 16;

  logic        clk, rst, comp_in, tx_busy;
  logic        sd_fb, sample_valid, tx_start;
  logic [15:0] sample;
  logic [7:0]  tx_dat, drop_cnt;

  logic        rst2, comp2, busy2;
  logic        sd_fb2, sv2, ts2;
  logic [15:0] sample2;
  logic [7:0]  tx_dat2, drop2;

  int total = 0, bad = 0;

  lvds_sd_framer #(.DEC_W(4), .SYNC_BYTE(8'hA5), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .comp_in(comp_in), .sd_fb(sd_fb), .sample(sample),
    .sample_valid(sample_valid), .tx_dat(tx_dat), .tx_start(tx_start),
    .tx_busy(tx_busy), .drop_cnt(drop_cnt));

  lvds_sd_framer #(.DEC_W(10), .SYNC_BYTE(8'hA5), .DROP_W(8)) dut2 (
    .clk(clk), .rst(rst2), .comp_in(comp2), .sd_fb(sd_fb2), .sample(sample2),
    .sample_valid(sv2), .tx_dat(tx_dat2), .tx_start(ts2),
    .tx_busy(busy2), .drop_cnt(drop2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          armed = 0;
  int          ec = 0;
  bit          hist[8192];
  int          exp_sample, exp_drop, m_starts, valid_cnt, first_ts_ec;
  bit          m_in_prog, m_seen_high, prev_ts;
  logic [15:0] m_hold;
  logic [7:0]  last_byte, first_byte;
  logic [7:0]  tx_log[$];
  logic [7:0]  log2[$];

  function automatic int c(input int i);
    if (i >= 1 && i < 8192) return int'(hist[i]);
    return 0;
  endfunction

  function automatic logic [7:0] pkt_byte(input int n, input logic [15:0] h);
    if (n == 0) return 8'hA5;
    if (n == 1) return h[15:8];
    return h[7:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ec    = 0;
      armed = 1;
    end else if (armed) begin
      ec++;
      if (ec < 8192) hist[ec] = comp_in;
    end
  end

  always @(negedge clk) begin : cmp
    int k;
    bit mv;
    if (armed) begin
      k  = ec;
      mv = (k > 0) && (k % W == 0);
      if (k == 0) begin
        exp_sample = 0; exp_drop = 0; m_in_prog = 0; m_starts = 0; m_seen_high = 0;
        valid_cnt = 0; first_ts_ec = -1; prev_ts = 0;
        tx_log.delete();
        chk("rst_tx_dat", tx_dat, 0);
        chk("rst_tx_start", tx_start, 0);
      end else if (mv) begin
        exp_sample = 0;
        for (int i = k - W - 1; i <= k - 2; i++) exp_sample += c(i);
      end
      chk("sd_fb", sd_fb, c(k - 2));
      chk("sample_valid", sample_valid, mv);
      chk("sample", sample, exp_sample);
      chk("drop_cnt", drop_cnt, exp_drop);
      if (rst) chk("start_in_rst", tx_start, 0);
      if (sample_valid) valid_cnt++;
      if (tx_start) begin
        chk("start_in_packet", m_in_prog && (m_starts < 3), 1);
        chk("start_busy_low", tx_busy, 0);
        chk("start_single_cycle", prev_ts, 0);
        chk("tx_byte", tx_dat, pkt_byte(m_starts, m_hold));
        tx_log.push_back(tx_dat);
        if (first_ts_ec < 0) begin
          first_ts_ec = k;
          first_byte  = tx_dat;
        end
        last_byte   = tx_dat;
        m_starts++;
        m_seen_high = 0;
      end else if (tx_busy && m_starts > 0 && m_in_prog) begin
        chk("tx_dat_stable", tx_dat, last_byte);
        m_seen_high = 1;
      end
      prev_ts = tx_start;
      // what the framer does at the coming edge
      if (!rst) begin
        if (mv) begin
          if (!m_in_prog) begin
            m_in_prog = 1; m_hold = exp_sample[15:0]; m_starts = 0; m_seen_high = 0;
          end else if (exp_drop < 255) begin
            exp_drop++;
          end
        end
        if (m_in_prog && m_starts == 3 && m_seen_high && !tx_busy) m_in_prog = 0;
      end
    end
  end

  // ---------------- UART TX responders ----------------
  int busy_len = 1;
  bit force_busy = 0;
  initial begin : tx1
    bit pend;
    int left;
    tx_busy = 1'b0;
    left    = 0;
    forever begin
      @(negedge clk);
      pend = (tx_start === 1'b1);
      @(posedge clk);
      #1;
      if (pend) left = busy_len;
      else if (left > 0) left--;
      tx_busy = force_busy || (left > 0);
    end
  end

  initial begin : tx2
    bit pend;
    int left;
    busy2 = 1'b0;
    left  = 0;
    forever begin
      @(negedge clk);
      pend = (ts2 === 1'b1);
      if (pend) log2.push_back(tx_dat2);
      @(posedge clk);
      #1;
      if (pend) left = 1;
      else if (left > 0) left--;
      busy2 = (left > 0);
    end
  end

  // ---------------- stimulus ----------------
  bit toggle_en = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (toggle_en) comp_in = ~comp_in;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin : main
    bit reached;
    rst = 1'b1; comp_in = 1'b0; rst2 = 1'b1; comp2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;

    // comp_in low: empty windows, packets A5 00 00
    do_reset();
    tick(65);
    chk("zero_valid_count", valid_cnt, 4);
    chk("zero_sample", sample, 0);
    chk("zero_log_size", tx_log.size() >= 3, 1);
    chk("zero_b0", tx_log[0], 8'hA5);
    chk("zero_b1", tx_log[1], 8'h00);
    chk("zero_b2", tx_log[2], 8'h00);

    // comp_in high: partial first window (14), then full (16)
    comp_in = 1'b1;
    do_reset();
    tick(45);
    chk("ones_sample", sample, 16);
    chk("ones_log_size", tx_log.size() >= 6, 1);
    chk("ones_p0_b2", tx_log[2], 8'h0E);
    chk("ones_p1_b0", tx_log[3], 8'hA5);
    chk("ones_p1_b1", tx_log[4], 8'h00);
    chk("ones_p1_b2", tx_log[5], 8'h10);

    // alternating input: half scale
    comp_in = 1'b0;
    do_reset();
    toggle_en = 1;
    tick(50);
    toggle_en = 0;
    chk("toggle_sample", sample, 8);

    // busy already high when the first sample lands
    comp_in = 1'b0;
    force_busy = 1;
    do_reset();
    tick(40);
    chk("held_no_start", first_ts_ec, 32'hFFFF_FFFF);
    chk("held_drop", drop_cnt, 1);
    force_busy = 0;
    tick(20);
    chk("held_log_size", tx_log.size(), 3);
    chk("held_b0", tx_log[0], 8'hA5);
    chk("held_b2", tx_log[2], 8'h00);

    // slow TX: drops saturate
    busy_len = 200;
    do_reset();
    tick(5000);
    chk("drop_saturated", drop_cnt, 255);

    // reset while waiting for the last byte to finish
    busy_len = 5;
    comp_in  = 1'b1;
    do_reset();
    reached = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (m_in_prog && m_starts == 3 && m_seen_high) begin
        reached = 1;
        break;
      end
    end
    chk("wait_fall_reached", reached, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_drop", drop_cnt, 0);
    chk("rst_mid_tx_dat", tx_dat, 0);
    chk("rst_mid_sample", sample, 0);
    chk("rst_mid_start", tx_start, 0);
    tick(36);
    chk("fresh_first_start", first_ts_ec, 18);
    chk("fresh_first_byte", first_byte, 8'hA5);
    chk("fresh_log_size", tx_log.size() >= 3, 1);
    chk("fresh_b2", tx_log[2], 8'h0E);

    // wide window instance, comp held high since its reset
    chk("w10_sample", sample2, 1024);
    chk("w10_drop", drop2, 0);
    chk("w10_log_size", log2.size() >= 6, 1);
    chk("w10_p0_b1", log2[1], 8'h03);
    chk("w10_p0_b2", log2[2], 8'hFE);
    chk("w10_p1_b0", log2[3], 8'hA5);
    chk("w10_p1_b1", log2[4], 8'h04);
    chk("w10_p1_b2", log2[5], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
